sram_port_arbiter: RTL and testbench

Shares the single SRAM controller port between two requesters: port 0 (MEM stage data access) and port 1 (IF stage instruction fetch).
- Grants one requester at a time and holds its command stable until the controller reports completion.
- Returns read data and a per-port ready for pipeline freeze.
- Sits between the pipeline stages and the SRAM controller instance.

---
 rtl/sram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the single SRAM controller: data port (0) and fetch port (1).
// Grants one requester at a time, holds its command until ctrl_ready, then reports via pN_ready.
module sram_port_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_rd_en,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_rd_en,
    input  logic [31:0] p1_addr,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic        ctrl_rd_en,
    output logic        ctrl_wr_en,
    output logic [31:0] ctrl_addr,
    output logic [31:0] ctrl_wdata,
    input  logic [31:0] ctrl_rdata,
    input  logic        ctrl_ready,
    output logic        grant_id,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    logic [1:0] state;
    logic       last_grant;
    logic [7:0] wdog;
    logic       req0;
    logic       req1;
    logic       pick1;
    logic       done0;
    logic       done1;

    assign req0 = p0_rd_en | p0_wr_en;
    assign req1 = p1_rd_en;

    // Port 1 wins when it is the only requester, or on a tie under round-robin after a port-0 grant.
    assign pick1 = req1 & (~req0 | ((PRIO_MODE == 0) & ~last_grant));

    assign busy  = (state == BUSY0) | (state == BUSY1);
    assign done0 = (state == DONE) & ~grant_id;
    assign done1 = (state == DONE) & grant_id;

    // NOTE: ready is gated by the reset input so every output reads 0 while reset is held,
    // even though the ready equation itself is combinational on the request enables.
    assign p0_ready = rst & (~req0 | done0);
    assign p1_ready = rst & (~req1 | done1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            wdog        <= '0;
            err_timeout <= 1'b0;
            ctrl_rd_en  <= 1'b0;
            ctrl_wr_en  <= 1'b0;
            ctrl_addr   <= '0;
            ctrl_wdata  <= '0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant_id   <= pick1;
                        last_grant <= pick1;
                        wdog       <= '0;
                        if (pick1) begin
                            ctrl_addr  <= p1_addr;
                            ctrl_wdata <= '0;
                            ctrl_rd_en <= 1'b1;
                            ctrl_wr_en <= 1'b0;
                            state      <= BUSY1;
                        end else begin
                            // A simultaneous read and write on port 0 is issued as a write.
                            ctrl_addr  <= p0_addr;
                            ctrl_wdata <= p0_wdata;
                            ctrl_rd_en <= p0_rd_en & ~p0_wr_en;
                            ctrl_wr_en <= p0_wr_en;
                            state      <= BUSY0;
                        end
                    end
                end
                BUSY0, BUSY1: begin
                    if (ctrl_ready) begin
                        if (ctrl_rd_en) begin
                            if (state == BUSY0) p0_rdata <= ctrl_rdata;
                            else                p1_rdata <= ctrl_rdata;
                        end
                        ctrl_rd_en <= 1'b0;
                        ctrl_wr_en <= 1'b0;
                        wdog       <= '0;
                        state      <= DONE;
                    end else begin
                        // The watchdog saturates at TIMEOUT; the transaction keeps waiting.
                        if (wdog != TIMEOUT_W) wdog <= wdog + 8'd1;
                        if (wdog == TIMEOUT_W - 8'd1) err_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a round-robin instance and a fixed-priority instance,
// each driven by a small SRAM controller model answering with addr ^ 0xDEADBEAF.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        p0_rd_en = 1'b0;
    logic        p0_wr_en = 1'b0;
    logic [31:0] p0_addr  = '0;
    logic [31:0] p0_wdata = '0;
    logic        p1_rd_en = 1'b0;
    logic [31:0] p1_addr  = '0;

    logic [31:0] a_p0_rdata, a_p1_rdata, a_ctrl_addr, a_ctrl_wdata;
    logic        a_p0_ready, a_p1_ready, a_ctrl_rd_en, a_ctrl_wr_en;
    logic        a_grant_id, a_busy, a_err_timeout;
    logic [31:0] a_ctrl_rdata = '0;
    logic        a_ctrl_ready = 1'b0;

    logic [31:0] b_p0_rdata, b_p1_rdata, b_ctrl_addr, b_ctrl_wdata;
    logic        b_p0_ready, b_p1_ready, b_ctrl_rd_en, b_ctrl_wr_en;
    logic        b_grant_id, b_busy, b_err_timeout;
    logic [31:0] b_ctrl_rdata = '0;
    logic        b_ctrl_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        gq[$];

    int lat_a = 0;
    int lat_b = 0;
    bit stall_a = 1'b0;
    bit stall_b = 1'b0;
    int cnt_a = 0;
    int cnt_b = 0;

    sram_port_arbiter #(.PRIO_MODE(0), .TIMEOUT(8)) dut_rr (
        .clk(clk), .rst(rst),
        .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(a_p0_rdata), .p0_ready(a_p0_ready),
        .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_rdata(a_p1_rdata), .p1_ready(a_p1_ready),
        .ctrl_rd_en(a_ctrl_rd_en), .ctrl_wr_en(a_ctrl_wr_en), .ctrl_addr(a_ctrl_addr),
        .ctrl_wdata(a_ctrl_wdata), .ctrl_rdata(a_ctrl_rdata), .ctrl_ready(a_ctrl_ready),
        .grant_id(a_grant_id), .busy(a_busy), .err_timeout(a_err_timeout)
    );

    sram_port_arbiter #(.PRIO_MODE(1), .TIMEOUT(8)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(b_p0_rdata), .p0_ready(b_p0_ready),
        .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_rdata(b_p1_rdata), .p1_ready(b_p1_ready),
        .ctrl_rd_en(b_ctrl_rd_en), .ctrl_wr_en(b_ctrl_wr_en), .ctrl_addr(b_ctrl_addr),
        .ctrl_wdata(b_ctrl_wdata), .ctrl_rdata(b_ctrl_rdata), .ctrl_ready(b_ctrl_ready),
        .grant_id(b_grant_id), .busy(b_busy), .err_timeout(b_err_timeout)
    );

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_BEAF;
    endfunction

    // Controller models: ready is raised lat cycles after the enable is first seen, unless stalled.
    always @(negedge clk) begin
        if (!rst || !(a_ctrl_rd_en || a_ctrl_wr_en)) begin
            a_ctrl_ready = 1'b0;
            cnt_a = 0;
        end else if (stall_a) begin
            a_ctrl_ready = 1'b0;
        end else if (cnt_a >= lat_a) begin
            a_ctrl_ready = 1'b1;
            cnt_a = 0;
        end else begin
            a_ctrl_ready = 1'b0;
            cnt_a = cnt_a + 1;
        end
        a_ctrl_rdata = data_fn(a_ctrl_addr);
    end

    always @(negedge clk) begin
        if (!rst || !(b_ctrl_rd_en || b_ctrl_wr_en)) begin
            b_ctrl_ready = 1'b0;
            cnt_b = 0;
        end else if (stall_b) begin
            b_ctrl_ready = 1'b0;
        end else if (cnt_b >= lat_b) begin
            b_ctrl_ready = 1'b1;
            cnt_b = 0;
        end else begin
            b_ctrl_ready = 1'b0;
            cnt_b = cnt_b + 1;
        end
        b_ctrl_rdata = data_fn(b_ctrl_addr);
    end

    task automatic do_reset();
        rst = 1'b0;
        p0_rd_en = 1'b0; p0_wr_en = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_rd_en = 1'b0; p1_addr = '0;
        stall_a = 1'b0; stall_b = 1'b0; lat_a = 0; lat_b = 0;
        q0.delete(); q1.delete(); gq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_a_p0_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (a_p0_ready) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit held_low;
        do_reset();
        stall_a = 1'b1;
        p0_addr = 32'h80;
        p0_rd_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (a_ctrl_rd_en !== 1'b1 || a_busy !== 1'b1 || a_p0_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_pre_busy: got rd_en=%b busy=%b ready=%b expected 1 1 0",
                     a_ctrl_rd_en, a_busy, a_p0_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_ctrl_rd_en, a_ctrl_wr_en, a_busy, a_grant_id, a_err_timeout, a_p0_ready, a_p1_ready} !== 7'd0 ||
            a_ctrl_addr !== '0 || a_ctrl_wdata !== '0 || a_p0_rdata !== '0 || a_p1_rdata !== '0) begin
            failures++;
            $display("FAIL reset_async_a: got flags=%b addr=%h rdata0=%h expected all zero",
                     {a_ctrl_rd_en, a_ctrl_wr_en, a_busy, a_grant_id, a_err_timeout, a_p0_ready, a_p1_ready},
                     a_ctrl_addr, a_p0_rdata);
        end
        checks++;
        if ({b_ctrl_rd_en, b_ctrl_wr_en, b_busy, b_grant_id, b_err_timeout, b_p0_ready, b_p1_ready} !== 7'd0 ||
            b_ctrl_addr !== '0 || b_p0_rdata !== '0) begin
            failures++;
            $display("FAIL reset_async_b: got flags=%b addr=%h rdata0=%h expected all zero",
                     {b_ctrl_rd_en, b_ctrl_wr_en, b_busy, b_grant_id, b_err_timeout, b_p0_ready, b_p1_ready},
                     b_ctrl_addr, b_p0_rdata);
        end
        held_low = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_p0_ready !== 1'b0 || a_ctrl_rd_en !== 1'b0) held_low = 1'b0;
        end
        checks++;
        if (!held_low) begin
            failures++;
            $display("FAIL reset_no_ready_pulse: got ready or enable during reset, expected 0");
        end
        p0_rd_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_p0_ready !== 1'b1 || a_ctrl_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b ready=%b rd_en=%b expected 0 1 0",
                     a_busy, a_p0_ready, a_ctrl_rd_en);
        end
    endtask

    task automatic test_single_read();
        int ready_at = 0;
        bit addr_ok = 1'b0;
        logic [31:0] exp;
        do_reset();
        lat_a = 3;
        q0.push_back(32'hDEAD_BEEF);
        p0_addr = 32'h0000_0040;
        p0_rd_en = 1'b1;
        for (int n = 1; n <= 20 && ready_at == 0; n++) begin
            @(negedge clk);
            if (n == 1) addr_ok = (a_ctrl_rd_en === 1'b1 && a_ctrl_wr_en === 1'b0 && a_ctrl_addr === 32'h40);
            if (a_p0_ready === 1'b1) ready_at = n;
        end
        checks++;
        if (!addr_ok) begin
            failures++;
            $display("FAIL single_ctrl_cmd: got command not issued the cycle after request, expected rd addr 40");
        end
        checks++;
        if (ready_at != 5) begin
            failures++;
            $display("FAIL single_latency: got ready at cycle %0d expected 5", ready_at);
        end
        checks++;
        if (q0.size() == 0) begin
            failures++;
            $display("FAIL single_data: got empty scoreboard expected one entry");
        end else begin
            exp = q0.pop_front();
            if (a_p0_rdata !== exp) begin
                failures++;
                $display("FAIL single_data: got %h expected %h", a_p0_rdata, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (a_p0_ready !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse_width: got ready=%b busy=%b expected 0 0", a_p0_ready, a_busy);
        end
        p0_rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (a_p0_ready !== 1'b1 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_after: got ready=%b busy=%b expected 1 0", a_p0_ready, a_busy);
        end
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        bit prev_busy = 1'b0;
        logic exp_g;
        logic [31:0] exp;
        do_reset();
        lat_a = 1;
        p0_wdata = 32'hFFFF_FFFF;
        gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
        p0_addr = 32'h200; q0.push_back(data_fn(32'h200)); p0_rd_en = 1'b1;
        p1_addr = 32'h300; q1.push_back(data_fn(32'h300)); p1_rd_en = 1'b1;
        for (int c = 0; c < 80 && (n0 < 2 || n1 < 2); c++) begin
            @(negedge clk);
            if (a_busy && !prev_busy) begin
                checks++;
                if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL rr_grant_order: got extra grant to %b expected none", a_grant_id);
                end else begin
                    exp_g = gq.pop_front();
                    if (a_grant_id !== exp_g) begin
                        failures++;
                        $display("FAIL rr_grant_order: got %b expected %b", a_grant_id, exp_g);
                    end
                    checks++;
                    if (a_ctrl_wdata !== (exp_g ? 32'h0 : 32'hFFFF_FFFF)) begin
                        failures++;
                        $display("FAIL rr_wdata: got %h for grant %b", a_ctrl_wdata, exp_g);
                    end
                end
            end
            prev_busy = a_busy;
            if (a_p0_ready && p0_rd_en) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL rr_p0_data: got unexpected ready with %h expected none", a_p0_rdata);
                end else begin
                    exp = q0.pop_front();
                    if (a_p0_rdata !== exp) begin
                        failures++;
                        $display("FAIL rr_p0_data: got %h expected %h", a_p0_rdata, exp);
                    end
                end
                n0++;
                if (n0 < 2) begin
                    p0_addr = 32'h204; q0.push_back(data_fn(32'h204));
                end else p0_rd_en = 1'b0;
            end
            if (a_p1_ready && p1_rd_en) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL rr_p1_data: got unexpected ready with %h expected none", a_p1_rdata);
                end else begin
                    exp = q1.pop_front();
                    if (a_p1_rdata !== exp) begin
                        failures++;
                        $display("FAIL rr_p1_data: got %h expected %h", a_p1_rdata, exp);
                    end
                end
                n1++;
                if (n1 < 2) begin
                    p1_addr = 32'h304; q1.push_back(data_fn(32'h304));
                end else p1_rd_en = 1'b0;
            end
        end
        checks++;
        if (n0 != 2 || n1 != 2 || gq.size() != 0) begin
            failures++;
            $display("FAIL rr_complete: got n0=%0d n1=%0d grants_left=%0d expected 2 2 0", n0, n1, gq.size());
        end
    endtask

    task automatic test_fixed_prio();
        int n0 = 0;
        int n1 = 0;
        bit prev_busy = 1'b0;
        logic exp_g;
        logic [31:0] exp;
        do_reset();
        lat_b = 0;
        gq.push_back(1'b0); gq.push_back(1'b0); gq.push_back(1'b0); gq.push_back(1'b1);
        p1_addr = 32'h500; q1.push_back(data_fn(32'h500)); p1_rd_en = 1'b1;
        p0_addr = 32'h600; q0.push_back(data_fn(32'h600)); p0_rd_en = 1'b1;
        for (int c = 0; c < 80 && n1 < 1; c++) begin
            @(negedge clk);
            if (b_busy && !prev_busy) begin
                checks++;
                if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL fp_grant_order: got extra grant to %b expected none", b_grant_id);
                end else begin
                    exp_g = gq.pop_front();
                    if (b_grant_id !== exp_g) begin
                        failures++;
                        $display("FAIL fp_grant_order: got %b expected %b", b_grant_id, exp_g);
                    end
                end
            end
            prev_busy = b_busy;
            if (b_p0_ready && p0_rd_en) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL fp_p0_data: got unexpected ready with %h expected none", b_p0_rdata);
                end else begin
                    exp = q0.pop_front();
                    if (b_p0_rdata !== exp) begin
                        failures++;
                        $display("FAIL fp_p0_data: got %h expected %h", b_p0_rdata, exp);
                    end
                end
                n0++;
                if (n0 < 3) begin
                    p0_addr = 32'h600 + 32'(4 * n0); q0.push_back(data_fn(p0_addr));
                end else p0_rd_en = 1'b0;
            end
            if (b_p1_ready && p1_rd_en) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL fp_p1_data: got unexpected ready with %h expected none", b_p1_rdata);
                end else begin
                    exp = q1.pop_front();
                    if (b_p1_rdata !== exp) begin
                        failures++;
                        $display("FAIL fp_p1_data: got %h expected %h", b_p1_rdata, exp);
                    end
                end
                n1++;
                p1_rd_en = 1'b0;
            end
        end
        checks++;
        if (n0 != 3 || n1 != 1 || gq.size() != 0) begin
            failures++;
            $display("FAIL fp_complete: got n0=%0d n1=%0d grants_left=%0d expected 3 1 0", n0, n1, gq.size());
        end
    endtask

    task automatic test_write_conflict();
        bit ok;
        logic [31:0] exp;
        do_reset();
        lat_a = 0;
        p0_addr = 32'h40; q0.push_back(32'hDEAD_BEEF); p0_rd_en = 1'b1;
        wait_a_p0_ready(ok);
        checks++;
        exp = q0.pop_front();
        if (!ok || a_p0_rdata !== exp) begin
            failures++;
            $display("FAIL wr_setup_read: got ok=%b data=%h expected %h", ok, a_p0_rdata, exp);
        end
        p0_rd_en = 1'b0;
        @(negedge clk);
        p0_addr = 32'h100; p0_wdata = 32'h1234_5678;
        p0_rd_en = 1'b1; p0_wr_en = 1'b1;
        q0.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (a_ctrl_wr_en !== 1'b1 || a_ctrl_rd_en !== 1'b0 ||
            a_ctrl_wdata !== 32'h1234_5678 || a_ctrl_addr !== 32'h100) begin
            failures++;
            $display("FAIL wr_ctrl_cmd: got wr=%b rd=%b wdata=%h addr=%h expected 1 0 12345678 100",
                     a_ctrl_wr_en, a_ctrl_rd_en, a_ctrl_wdata, a_ctrl_addr);
        end
        wait_a_p0_ready(ok);
        checks++;
        exp = q0.pop_front();
        if (!ok || a_p0_rdata !== exp) begin
            failures++;
            $display("FAIL wr_rdata_kept: got ok=%b data=%h expected %h", ok, a_p0_rdata, exp);
        end
        p0_rd_en = 1'b0; p0_wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int busy_n = 0;
        int err_at = 0;
        bit ok;
        logic [31:0] exp;
        do_reset();
        stall_a = 1'b1;
        p0_addr = 32'h700; q0.push_back(data_fn(32'h700)); p0_rd_en = 1'b1;
        for (int c = 0; c < 30 && busy_n < 9; c++) begin
            @(negedge clk);
            if (a_busy) busy_n++;
            if (a_err_timeout === 1'b1 && err_at == 0) err_at = busy_n;
        end
        checks++;
        if (err_at != 9) begin
            failures++;
            $display("FAIL to_set_point: got err_timeout first at busy cycle %0d expected 9", err_at);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (a_err_timeout !== 1'b1 || a_busy !== 1'b1 || a_ctrl_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky_wait: got err=%b busy=%b rd_en=%b expected 1 1 1",
                     a_err_timeout, a_busy, a_ctrl_rd_en);
        end
        stall_a = 1'b0;
        wait_a_p0_ready(ok);
        checks++;
        exp = q0.pop_front();
        if (!ok || a_p0_rdata !== exp || a_err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_late_complete: got ok=%b data=%h err=%b expected data %h err 1",
                     ok, a_p0_rdata, a_err_timeout, exp);
        end
        p0_rd_en = 1'b0;
        @(negedge clk);
        p0_addr = 32'h704; q0.push_back(data_fn(32'h704)); p0_rd_en = 1'b1;
        wait_a_p0_ready(ok);
        checks++;
        exp = q0.pop_front();
        if (!ok || a_p0_rdata !== exp || a_err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_next_read: got ok=%b data=%h err=%b expected data %h err 1",
                     ok, a_p0_rdata, a_err_timeout, exp);
        end
        p0_rd_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (a_err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_reset_clear: got %b expected 0", a_err_timeout);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fixed_prio();
        test_write_conflict();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit reached");
    end

endmodule
